// File: rtl/ramen_order_feeder.sv
// Order-queueing front end for the ramen stage: buffers customer orders, replays each
// with the two-cycle in_valid handshake, and reports per-order results and per-day counts.
module ramen_order_feeder #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cust_valid,
    output logic       cust_ready,
    input  logic [1:0] cust_type,
    input  logic       cust_portion,
    input  logic       cust_last,
    output logic [7:0] cust_tag,
    output logic       in_valid,
    output logic [1:0] ramen_type,
    output logic       portion,
    output logic       selling,
    input  logic       out_valid_order,
    input  logic       success,
    input  logic       out_valid_tot,
    output logic       resp_valid,
    output logic       resp_success,
    output logic [7:0] resp_tag,
    output logic       day_done,
    output logic [7:0] ok_cnt,
    output logic [7:0] fail_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TAG_W = 8;

    typedef struct packed {
        logic [1:0]       rtype;
        logic             portion;
        logic             last;
        logic [TAG_W-1:0] tag;
    } order_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND0,
        ST_SEND1,
        ST_WAIT,
        ST_TOTAL
    } state_t;

    state_t             state;
    order_t             mem [DEPTH];
    order_t             head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [TAG_W-1:0]   tag_q;
    logic               inflight_last;
    logic [TAG_W-1:0]   inflight_tag;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               order_done;
    logic               tot_done;

    // Readiness looks only at the current count; a same-cycle pop does not open a slot.
    assign cust_ready = (count < CNT_W'(DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = cust_valid && cust_ready;
    assign pop        = (state == ST_SEND1);
    assign head       = mem[rd_ptr];
    assign cust_tag   = tag_q;
    assign order_done = (state == ST_WAIT) && out_valid_order;
    assign tot_done   = (state == ST_TOTAL) && out_valid_tot;

    // Order storage; contents need no reset because count guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{rtype: cust_type, portion: cust_portion,
                             last: cust_last, tag: tag_q};
        end
    end

    // FIFO pointers, occupancy and the free-running order tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            tag_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                tag_q  <= tag_q + TAG_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sequencer: two send cycles per order, then wait for the verdict (and totals on the last).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            inflight_last <= 1'b0;
            inflight_tag  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state <= ST_SEND0;
                    end
                end
                ST_SEND0: begin
                    state <= ST_SEND1;
                end
                ST_SEND1: begin
                    state         <= ST_WAIT;
                    inflight_last <= head.last;
                    inflight_tag  <= head.tag;
                end
                ST_WAIT: begin
                    if (out_valid_order) begin
                        if (inflight_last) begin
                            state <= ST_TOTAL;
                        end else if (!fifo_empty) begin
                            state <= ST_SEND0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_TOTAL: begin
                    if (out_valid_tot) begin
                        state <= fifo_empty ? ST_IDLE : ST_SEND0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Ramen-stage drive is a pure decode of state and the head/in-flight registers.
    always_comb begin
        in_valid   = 1'b0;
        ramen_type = 2'd0;
        portion    = 1'b0;
        selling    = 1'b0;
        case (state)
            ST_SEND0: begin
                in_valid   = 1'b1;
                ramen_type = head.rtype;
            end
            ST_SEND1: begin
                in_valid = 1'b1;
                portion  = head.portion;
            end
            ST_WAIT: begin
                selling = !inflight_last;
            end
            default: begin
                in_valid = 1'b0;
            end
        endcase
    end

    // Per-order result strobe and the day-close pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid   <= 1'b0;
            resp_success <= 1'b0;
            resp_tag     <= '0;
            day_done     <= 1'b0;
        end else begin
            resp_valid <= order_done;
            day_done   <= tot_done;
            if (order_done) begin
                resp_success <= success;
                resp_tag     <= inflight_tag;
            end
        end
    end

    // Day counters saturate, hold through the day_done cycle, then clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_cnt   <= '0;
            fail_cnt <= '0;
        end else if (day_done) begin
            ok_cnt   <= '0;
            fail_cnt <= '0;
        end else if (order_done) begin
            if (success && (ok_cnt != 8'hFF)) begin
                ok_cnt <= ok_cnt + 8'(1);
            end
            if (!success && (fail_cnt != 8'hFF)) begin
                fail_cnt <= fail_cnt + 8'(1);
            end
        end
    end

endmodule

// File: tb/tb_ramen_order_feeder.sv
// Self-checking bench for ramen_order_feeder; the bench plays both customer and ramen stage.
module tb_ramen_order_feeder;

    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cust_valid = 1'b0;
    logic       cust_ready;
    logic [1:0] cust_type = 2'd0;
    logic       cust_portion = 1'b0;
    logic       cust_last = 1'b0;
    logic [7:0] cust_tag;
    logic       in_valid;
    logic [1:0] ramen_type;
    logic       portion;
    logic       selling;
    logic       out_valid_order = 1'b0;
    logic       success = 1'b0;
    logic       out_valid_tot = 1'b0;
    logic       resp_valid;
    logic       resp_success;
    logic [7:0] resp_tag;
    logic       day_done;
    logic [7:0] ok_cnt;
    logic [7:0] fail_cnt;

    ramen_order_feeder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cust_valid(cust_valid), .cust_ready(cust_ready), .cust_type(cust_type),
        .cust_portion(cust_portion), .cust_last(cust_last), .cust_tag(cust_tag),
        .in_valid(in_valid), .ramen_type(ramen_type), .portion(portion), .selling(selling),
        .out_valid_order(out_valid_order), .success(success), .out_valid_tot(out_valid_tot),
        .resp_valid(resp_valid), .resp_success(resp_success), .resp_tag(resp_tag),
        .day_done(day_done), .ok_cnt(ok_cnt), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] t;
        logic       p;
        logic       l;
        logic [7:0] tag;
    } ord_t;

    // Reference model: pending orders, next tag, day tallies.
    ord_t       mq[$];
    logic [7:0] m_tag = 8'd0;
    int         m_ok = 0;
    int         m_fail = 0;
    int         n_acc = 0;
    int         acc_cyc = 0;
    int         errors = 0;
    int         checks = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [1:0] t, input logic p, input logic l);
        ord_t o;
        chk("acc_ready", cust_ready, (mq.size() < int'(DEPTH)));
        chk("acc_tag", cust_tag, m_tag);
        cust_valid = 1'b1; cust_type = t; cust_portion = p; cust_last = l;
        o.t = t; o.p = p; o.l = l; o.tag = m_tag;
        mq.push_back(o);
        m_tag++;
        n_acc++;
        acc_cyc = cyc;
        tick;
        cust_valid = 1'b0;
        cust_type = 2'($urandom_range(0, 3));
        cust_portion = 1'($urandom_range(0, 1));
        cust_last = 1'($urandom_range(0, 1));
    endtask

    task automatic accept_rand(input logic allow_last);
        accept(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               allow_last && ($urandom_range(0, 15) == 0));
    endtask

    // Finds the SEND0 cycle, checks both send cycles, returns in the first WAIT cycle.
    task automatic serve_send(output ord_t o, output int start);
        int w = 0;
        while (in_valid !== 1'b1 && w < 40) begin
            tick;
            w++;
        end
        start = cyc;
        o.t = 2'd0; o.p = 1'b0; o.l = 1'b0; o.tag = 8'd0;
        checks++;
        assert (mq.size() != 0) else begin
            errors++;
            $error("FAIL model_queue observed=empty expected=pending_order");
        end
        if (mq.size() != 0) o = mq[0];
        chk("send0_valid", in_valid, 1'b1);
        chk("send0_type", ramen_type, o.t);
        chk("send0_portion", portion, 1'b0);
        chk("send0_selling", selling, 1'b0);
        chk("send0_ready", cust_ready, (mq.size() < int'(DEPTH)));
        out_valid_tot = 1'($urandom_range(0, 1));
        tick;
        chk("send1_valid", in_valid, 1'b1);
        chk("send1_portion", portion, o.p);
        chk("send1_type", ramen_type, 2'd0);
        chk("send1_resp", resp_valid, 1'b0);
        chk("send1_day_done", day_done, 1'b0);
        chk("send1_ok", ok_cnt, m_ok);
        chk("send1_fail", fail_cnt, m_fail);
        out_valid_tot = 1'b0;
        tick;
        if (mq.size() != 0) void'(mq.pop_front());
        chk("wait_in_valid", in_valid, 1'b0);
    endtask

    // Holds WAIT for 'delay' extra cycles, answers, checks the result and any day close.
    task automatic serve_resp(input ord_t o, input int delay, input logic succ, input int tot_delay);
        chk("wait_selling", selling, !o.l);
        for (int i = 0; i < delay; i++) begin
            tick;
            chk("wait_hold_selling", selling, !o.l);
            chk("wait_hold_resp", resp_valid, 1'b0);
        end
        tick;
        chk("wait_resp_selling", selling, !o.l);
        out_valid_order = 1'b1;
        success = succ;
        tick;
        out_valid_order = 1'b0;
        success = 1'($urandom_range(0, 1));
        if (succ) begin
            if (m_ok < 255) m_ok++;
        end else begin
            if (m_fail < 255) m_fail++;
        end
        chk("resp_valid", resp_valid, 1'b1);
        chk("resp_success", resp_success, succ);
        chk("resp_tag", resp_tag, o.tag);
        chk("resp_ok", ok_cnt, m_ok);
        chk("resp_fail", fail_cnt, m_fail);
        if (o.l) begin
            chk("total_selling", selling, 1'b0);
            chk("total_in_valid", in_valid, 1'b0);
            for (int i = 0; i < tot_delay; i++) begin
                out_valid_order = 1'b1;
                tick;
                chk("total_hold_done", day_done, 1'b0);
                chk("total_hold_resp", resp_valid, 1'b0);
                chk("total_hold_in_valid", in_valid, 1'b0);
            end
            out_valid_order = 1'b0;
            out_valid_tot = 1'b1;
            tick;
            out_valid_tot = 1'b0;
            chk("day_done", day_done, 1'b1);
            chk("day_ok", ok_cnt, m_ok);
            chk("day_fail", fail_cnt, m_fail);
            m_ok = 0;
            m_fail = 0;
        end
    endtask

    initial begin
        ord_t o;
        ord_t h;
        ord_t bq[4];
        int   st[4];
        int   s;
        int   r;

        #2 rst_n = 1'b0;
        repeat (3) tick;
        chk("rst_ready", cust_ready, 1'b1);
        chk("rst_tag", cust_tag, 8'd0);
        chk("rst_in_valid", in_valid, 1'b0);
        chk("rst_selling", selling, 1'b0);
        chk("rst_resp", resp_valid, 1'b0);
        chk("rst_day_done", day_done, 1'b0);
        chk("rst_ok", ok_cnt, 8'd0);
        chk("rst_fail", fail_cnt, 8'd0);
        rst_n = 1'b1;
        tick;

        // Day close: third order is the last; one rejection.
        accept(2'd1, 1'b0, 1'b0);
        serve_send(o, s);
        serve_resp(o, 0, 1'b1, 0);
        accept(2'd3, 1'b1, 1'b0);
        serve_send(o, s);
        serve_resp(o, 0, 1'b0, 0);
        accept(2'd0, 1'b1, 1'b1);
        serve_send(o, s);
        serve_resp(o, 0, 1'b1, 0);
        tick;
        chk("day_clear_ok", ok_cnt, 8'd0);
        chk("day_clear_fail", fail_cnt, 8'd0);
        chk("day_done_pulse", day_done, 1'b0);

        // Single order with exact latency.
        accept(2'd2, 1'b1, 1'b0);
        out_valid_order = 1'b1;
        chk("t1_in_valid", in_valid, 1'b0);
        tick;
        out_valid_order = 1'b0;
        serve_send(o, s);
        chk("single_latency", s - acc_cyc, 2);
        serve_resp(o, 0, 1'b1, 0);
        chk("single_ok", ok_cnt, 8'd1);
        tick;
        chk("single_resp_drop", resp_valid, 1'b0);

        // Back-to-back: hold one order in WAIT, queue four, then release.
        accept_rand(1'b0);
        serve_send(h, s);
        for (int i = 0; i < 4; i++) accept_rand(1'b0);
        serve_resp(h, 2, 1'($urandom_range(0, 1)), 0);
        r = cyc;
        for (int i = 0; i < 4; i++) begin
            serve_send(bq[i], st[i]);
            serve_resp(bq[i], 0, 1'($urandom_range(0, 1)), 0);
        end
        chk("b2b_first", st[0] - r, 0);
        for (int i = 1; i < 4; i++) chk("b2b_spacing", st[i] - st[i-1], 4);

        // FIFO full while one order is in flight.
        accept_rand(1'b0);
        serve_send(h, s);
        for (int i = 0; i < int'(DEPTH); i++) accept_rand(1'b0);
        chk("full_ready", cust_ready, 1'b0);
        cust_valid = 1'b1; cust_type = 2'd3; cust_portion = 1'b0; cust_last = 1'b0;
        tick;
        chk("full_hold_ready", cust_ready, 1'b0);
        chk("full_hold_tag", cust_tag, m_tag);
        serve_resp(h, 0, 1'b1, 0);
        serve_send(o, s);
        chk("full_ready_after_pop", cust_ready, 1'b1);
        chk("full_ninth_tag", cust_tag, m_tag);
        h.t = 2'd3; h.p = 1'b0; h.l = 1'b0; h.tag = m_tag;
        mq.push_back(h);
        m_tag++;
        n_acc++;
        tick;
        cust_valid = 1'b0;
        chk("full_after_ninth", cust_ready, 1'b0);
        serve_resp(o, 0, 1'b0, 0);
        while (mq.size() != 0) begin
            serve_send(o, s);
            serve_resp(o, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
        end

        // Reset while an order is in WAIT with more queued.
        accept_rand(1'b0);
        serve_send(o, s);
        accept_rand(1'b0);
        accept_rand(1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", cust_ready, 1'b1);
        chk("mid_rst_tag", cust_tag, 8'd0);
        chk("mid_rst_resp", resp_valid, 1'b0);
        chk("mid_rst_ok", ok_cnt, 8'd0);
        chk("mid_rst_fail", fail_cnt, 8'd0);
        chk("mid_rst_selling", selling, 1'b0);
        out_valid_order = 1'b1;
        tick;
        tick;
        out_valid_order = 1'b0;
        rst_n = 1'b1;
        mq.delete();
        m_tag = 8'd0;
        m_ok = 0;
        m_fail = 0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("post_rst_resp", resp_valid, 1'b0);
            chk("post_rst_in_valid", in_valid, 1'b0);
            chk("post_rst_ready", cust_ready, 1'b1);
        end

        // Random traffic through a full tag wrap, with occasional day closes.
        while (n_acc < 256) begin
            if (mq.size() == 0) accept_rand(1'b1);
            serve_send(o, s);
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                if (n_acc < 256 && mq.size() < int'(DEPTH)) accept_rand(1'b1);
            end
            serve_resp(o, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
        chk("tag_wrap", cust_tag, 8'd0);
        while (mq.size() != 0) begin
            serve_send(o, s);
            serve_resp(o, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
        repeat (3) tick;
        chk("end_idle", in_valid, 1'b0);
        chk("end_ready", cust_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ramen_order_feeder.md
# ramen_order_feeder

Upstream order-queueing stage for the ramen shop controller. It buffers customer orders in a small FIFO and replays each one to the ramen stage using that stage's two-cycle `in_valid` protocol. It drives `selling` so that the last order of a business day triggers the day's totals, and returns a tagged success/fail result per order plus per-day counters.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; must be a power of two, at least 2.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `cust_valid`, in, 1: customer order offered.
- `cust_ready`, out, 1: order accepted when `cust_valid && cust_ready`.
- `cust_type`, in, 2: ramen type (0 tonkotsu, 1 tonkotsu-soy, 2 miso, 3 miso-soy).
- `cust_portion`, in, 1: 0 = small, 1 = big.
- `cust_last`, in, 1: this order is the last of the business day.
- `cust_tag`, out, 8: tag assigned to the order accepted this cycle.
- `in_valid`, out, 1: to ramen stage.
- `ramen_type`, out, 2: to ramen stage.
- `portion`, out, 1: to ramen stage.
- `selling`, out, 1: to ramen stage.
- `out_valid_order`, in, 1: from ramen stage.
- `success`, in, 1: from ramen stage.
- `out_valid_tot`, in, 1: from ramen stage.
- `resp_valid`, out, 1: per-order result strobe.
- `resp_success`, out, 1: per-order result.
- `resp_tag`, out, 8: tag of the order whose result is being reported.
- `day_done`, out, 1: one-cycle pulse after the ramen stage reports day totals.
- `ok_cnt`, out, 8: successful orders so far in the current day.
- `fail_cnt`, out, 8: rejected orders so far in the current day.

## Operation
- **FIFO.** Each entry holds {type, portion, last, tag} (12 bits).
  - `cust_ready = (count < DEPTH)`. Readiness is computed from the current count only; a same-cycle pop does not free a slot.
  - Pointers wrap modulo `DEPTH`.
- **Tag counter.** 8 bits, reset to 0.
  - `cust_tag` shows the current value.
  - Increments on every accept and wraps 255 → 0.
  - It is never cleared at the end of a day.
- **FSM states:** IDLE, SEND0, SEND1, WAIT, TOTAL.
  - IDLE → SEND0 when the FIFO is non-empty.
  - SEND0 → SEND1 unconditionally.
    - `in_valid = 1`; `ramen_type` = head type.
  - SEND1 → WAIT unconditionally.
    - `in_valid = 1`; `portion` = head portion.
    - The head is popped at the end of this cycle.
    - The head's last bit and tag are captured into `inflight_last` and `inflight_tag`.
  - WAIT: `selling = !inflight_last`.
    - Stays in WAIT until `out_valid_order`.
    - If `inflight_last` is set, goes to TOTAL.
    - Otherwise goes to SEND0 if the FIFO is non-empty, else IDLE.
  - TOTAL: stays until `out_valid_tot`, then goes to SEND0 if the FIFO is non-empty, else IDLE.
- **Defaults.** Outside the states listed above, `in_valid`, `ramen_type`, `portion` and `selling` are 0. All four are combinational decodes of state and head/inflight registers.
- **Result reporting.** When `out_valid_order` is seen in WAIT:
  - On the next cycle: `resp_valid = 1`, `resp_success = success`, `resp_tag = inflight_tag`.
  - `ok_cnt` or `fail_cnt` increments, saturating at 255.
- **Day close.** When `out_valid_tot` is seen in TOTAL, `day_done` pulses on the next cycle. Both counters hold their values during the `day_done` cycle and are cleared to 0 on the following edge.
- **Ignored inputs.**
  - `out_valid_order` outside WAIT is ignored.
  - `out_valid_tot` outside TOTAL is ignored.
  - `success` is ignored unless `out_valid_order` is high.
- **Reset values.**
  - FIFO empty, tag 0, state IDLE.
  - All outputs 0, except `cust_ready = 1` and `cust_tag = 0`.
  - Reset mid-order discards the FIFO and the in-flight order; no `resp_valid` is produced for it.

## Timing
- Order accepted at t0 into an empty, idle block:
  - count = 1 at t1.
  - SEND0 (`in_valid`, type) at t2; SEND1 (`in_valid`, portion) at t3.
  - Ramen stage checks at t4 and responds with `out_valid_order` at t5.
  - `resp_valid` at t6.
- Back-to-back orders: the next SEND0 is at t6, the cycle the ramen stage returns to IDLE. Throughput is one order per 4 cycles.
- Last order of the day:
  - `selling = 0` during t4–t5.
  - Ramen stage drives `out_valid_tot` at t6.
  - `day_done` pulses at t7.
  - The next SEND0 is no earlier than t7, so `in_valid` is never driven while the ramen stage is outputting totals.
- `in_valid` is always exactly 2 consecutive cycles per order.

## Test plan
- **Reset, then a single order.** Accept type 2, portion 1, last 0 at t0. Required: `in_valid` high at t2–t3, `ramen_type = 2` at t2, `portion = 1` at t3. Drive `out_valid_order = 1`, `success = 1` at t5. Required: `resp_valid = 1`, `resp_success = 1`, `resp_tag = 0` at t6; `ok_cnt = 1`.
- **FIFO full.** Push 9 orders with no ramen response. Required: `cust_ready = 0` after 8 accepts; the 9th is accepted only after the first SEND1 pop.
- **Day close.** Third order has `cust_last = 1`. Required: `selling = 0` only in that order's WAIT. Drive `out_valid_tot` one cycle after its response. Required: `day_done` pulses with `ok_cnt`/`fail_cnt` = 2/1 (given one rejection); both counters read 0 on the next cycle.
- **Back-to-back.** 4 queued orders. Required: the `in_valid` pairs are spaced exactly 4 cycles apart (start cycles t2, t6, t10, t14).
- **Tag wrap.** After 256 accepts, `cust_tag` returns to 0; `resp_tag` matches in order.
- **Reset mid-operation.** Assert `rst_n = 0` during WAIT. Required: no `resp_valid`; FIFO empty; `cust_ready = 1`.
